// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/funct to the 4-bit control code, runs single-cycle ops
// with a registered result and unsigned mult as an iterative shift-add, behind valid/ready.
module alu_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [4:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       alu_ctrl,
  output logic             zero
);

  localparam int SH_W   = $clog2(WIDTH);
  localparam int N_ITER = WIDTH / MUL_BITS;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_SLL  = 4'b0001;
  localparam logic [3:0] CTRL_OR   = 4'b0010;
  localparam logic [3:0] CTRL_ADD  = 4'b0100;
  localparam logic [3:0] CTRL_ADDI = 4'b0101;
  localparam logic [3:0] CTRL_SRL  = 4'b0110;
  localparam logic [3:0] CTRL_MULT = 4'b0111;
  localparam logic [3:0] CTRL_SUB  = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic [3:0]           ctrl_q, ctrl_d;
  logic                 zero_q, zero_d;

  logic [3:0]           dec_ctrl;
  logic [WIDTH-1:0]     alu_res;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [SH_W-1:0]      shamt;

  always_comb begin
    dec_ctrl = CTRL_ADD;
    case (alu_op)
      2'b01: dec_ctrl = CTRL_SUB;
      2'b10: begin
        case (funct)
          5'b00001: dec_ctrl = CTRL_AND;
          5'b00010: dec_ctrl = CTRL_OR;
          5'b01000: dec_ctrl = CTRL_SLL;
          5'b01001: dec_ctrl = CTRL_SRL;
          5'b10000: dec_ctrl = CTRL_MULT;
          default:  dec_ctrl = CTRL_ADDI;
        endcase
      end
      default: dec_ctrl = CTRL_ADD;
    endcase
  end

  assign shamt = b[SH_W-1:0];

  always_comb begin
    alu_res = a + b;
    case (dec_ctrl)
      CTRL_AND: alu_res = a & b;
      CTRL_OR:  alu_res = a | b;
      CTRL_SLL: alu_res = a << shamt;
      CTRL_SRL: alu_res = a >> shamt;
      CTRL_SUB: alu_res = a - b;
      default:  alu_res = a + b;
    endcase
  end

  // The multiplicand register is pre-aligned to the current bit position, so each
  // retired multiplier bit contributes a plain shifted copy of it.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
    acc_sum = acc_q + partial;
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    ctrl_d      = ctrl_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec_ctrl == CTRL_MULT) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_W'(N_ITER);
            state_d  = MUL;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            ctrl_d      = dec_ctrl;
            zero_d      = (alu_res == '0);
            state_d     = DONE;
          end
        end
      end
      MUL: begin
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        acc_d    = acc_sum;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d    = acc_sum[WIDTH-1:0];
          result_hi_d = acc_sum[2*WIDTH-1:WIDTH];
          ctrl_d      = CTRL_MULT;
          zero_d      = (acc_sum[WIDTH-1:0] == '0);
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      ctrl_q      <= '0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      ctrl_q      <= ctrl_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign alu_ctrl  = ctrl_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: one instance retiring 1 multiplier bit per cycle,
// one retiring 4, driven in lockstep from the same stimulus.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [4:0]  funct;
  logic [31:0] a, b;
  logic        out_ready;

  logic        in_ready1, out_valid1, zero1;
  logic [31:0] result1, result_hi1;
  logic [3:0]  alu_ctrl1;
  logic        in_ready4, out_valid4, zero4;
  logic [31:0] result4, result_hi4;
  logic [3:0]  alu_ctrl4;

  int checks = 0;
  int errors = 0;
  int lat1, lat4, cyc;
  logic [63:0] prod;

  alu_exec_unit #(.WIDTH(32), .MUL_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .result_hi(result_hi1), .alu_ctrl(alu_ctrl1), .zero(zero1)
  );

  alu_exec_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .result_hi(result_hi4), .alu_ctrl(alu_ctrl4), .zero(zero4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, scramble the inputs after accept, and measure each instance's latency.
  task automatic run_op(input logic [1:0] op, input logic [4:0] f,
                        input logic [31:0] av, input logic [31:0] bv);
    alu_op = op; funct = f; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; alu_op = 2'($urandom); funct = 5'($urandom);
    cyc  = 1;
    lat1 = out_valid1 ? 1 : 0;
    lat4 = out_valid4 ? 1 : 0;
    while ((lat1 == 0 || lat4 == 0) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (lat1 == 0 && out_valid1) lat1 = cyc;
      if (lat4 == 0 && out_valid4) lat4 = cyc;
      if (cyc == 4) check("busy_in_ready", {63'd0, in_ready1}, 64'd0);
    end
  endtask

  task automatic expect_res(input string tag, input logic [31:0] res, input logic [31:0] hi,
                            input logic [3:0] ctrl, input int l1, input int l4);
    check({tag, "_res1"},  {32'd0, result1},    {32'd0, res});
    check({tag, "_hi1"},   {32'd0, result_hi1}, {32'd0, hi});
    check({tag, "_ctrl1"}, {60'd0, alu_ctrl1},  {60'd0, ctrl});
    check({tag, "_zero1"}, {63'd0, zero1},      {63'd0, (res == 32'd0)});
    check({tag, "_lat1"},  64'(lat1),           64'(l1));
    check({tag, "_res4"},  {32'd0, result4},    {32'd0, res});
    check({tag, "_hi4"},   {32'd0, result_hi4}, {32'd0, hi});
    check({tag, "_ctrl4"}, {60'd0, alu_ctrl4},  {60'd0, ctrl});
    check({tag, "_lat4"},  64'(lat4),           64'(l4));
    $display("op %s: result=%h hi=%h ctrl=%b zero=%b lat=%0d/%0d",
             tag, result1, result_hi1, alu_ctrl1, zero1, lat1, lat4);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_after"}, {63'd0, out_valid1}, 64'd0);
    check({tag, "_rdy1_after"}, {63'd0, in_ready1}, 64'd1);
    check({tag, "_rdy4_after"}, {63'd0, in_ready4}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct = 5'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready1}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid1}, 64'd0);
    check("rst_result", {32'd0, result1}, 64'd0);
    check("rst_result_hi", {32'd0, result_hi1}, 64'd0);
    check("rst_ctrl", {60'd0, alu_ctrl1}, 64'd0);
    check("rst_zero", {63'd0, zero1}, 64'd1);
    check("rst_in_ready4", {63'd0, in_ready4}, 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 5'd0, 32'd5, 32'd7);
    expect_res("add", 32'd12, 32'd0, 4'b0100, 1, 1);
    handoff("add");

    run_op(2'b01, 5'd0, 32'd3, 32'd3);
    expect_res("sub_zero", 32'd0, 32'd0, 4'b1100, 1, 1);
    handoff("sub_zero");

    run_op(2'b01, 5'd0, 32'd0, 32'd1);
    expect_res("sub_wrap", 32'hFFFF_FFFF, 32'd0, 4'b1100, 1, 1);
    handoff("sub_wrap");

    run_op(2'b10, 5'b01000, 32'd1, 32'h25);
    expect_res("sll5", 32'h20, 32'd0, 4'b0001, 1, 1);
    handoff("sll5");

    run_op(2'b10, 5'b01000, 32'hDEAD_BEEF, 32'h20);
    expect_res("sll0", 32'hDEAD_BEEF, 32'd0, 4'b0001, 1, 1);
    handoff("sll0");

    run_op(2'b10, 5'b01001, 32'h8000_0000, 32'd31);
    expect_res("srl31", 32'd1, 32'd0, 4'b0110, 1, 1);
    handoff("srl31");

    run_op(2'b10, 5'b00111, 32'd100, 32'd23);
    expect_res("addi", 32'd123, 32'd0, 4'b0101, 1, 1);
    handoff("addi");

    run_op(2'b10, 5'b00001, 32'h0000_F0F0, 32'h0000_FF00);
    expect_res("and", 32'h0000_F000, 32'd0, 4'b0000, 1, 1);
    handoff("and");

    run_op(2'b10, 5'b00010, 32'h0000_F0F0, 32'h0000_FF00);
    expect_res("or", 32'h0000_FFF0, 32'd0, 4'b0010, 1, 1);
    handoff("or");

    run_op(2'b11, 5'b01000, 32'h7FFF_FFFF, 32'd1);
    expect_res("op11_add", 32'h8000_0000, 32'd0, 4'b0100, 1, 1);
    handoff("op11_add");

    run_op(2'b10, 5'b10000, 32'hFFFF_FFFF, 32'd2);
    expect_res("mult_ff", 32'hFFFF_FFFE, 32'd1, 4'b0111, 33, 9);
    handoff("mult_ff");

    prod = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
    run_op(2'b10, 5'b10000, 32'h1234_5678, 32'h9ABC_DEF0);
    expect_res("mult_ref", prod[31:0], prod[63:32], 4'b0111, 33, 9);
    handoff("mult_ref");

    run_op(2'b10, 5'b10000, 32'h0001_0000, 32'h0001_0000);
    expect_res("mult_lozero", 32'd0, 32'd1, 4'b0111, 33, 9);
    handoff("mult_lozero");

    // Result must be held through a long consumer stall while new requests are refused.
    run_op(2'b00, 5'd0, 32'h11, 32'h22);
    expect_res("hold", 32'h33, 32'd0, 4'b0100, 1, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = $urandom; b = $urandom; alu_op = 2'b01;
      @(posedge clk); #1;
      check("hold_result", {32'd0, result1}, 64'h33);
      check("hold_ov", {63'd0, out_valid1}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready1}, 64'd0);
    end
    in_valid = 1'b0;
    check("hold_ctrl", {60'd0, alu_ctrl1}, {60'd0, 4'b0100});
    handoff("hold");

    // Reset in the middle of a multiply discards it.
    alu_op = 2'b10; funct = 5'b10000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midmul_busy", {63'd0, in_ready1}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", {63'd0, in_ready1}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid1}, 64'd0);
    check("midrst_result", {32'd0, result1}, 64'd0);
    check("midrst_result_hi", {32'd0, result_hi1}, 64'd0);
    check("midrst_zero", {63'd0, zero1}, 64'd1);
    check("midrst_in_ready4", {63'd0, in_ready4}, 64'd1);
    $display("op midmul_reset: in_ready=%b out_valid=%b result=%h", in_ready1, out_valid1, result1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
